// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Front-end controller for the ALU. Accepts one operation request at a time
// over a valid/ready handshake. For each request it drives the ALU command bus
// in this order: COM_LATCHOP, then EXEC_CYCLES NOP cycles, then COM_WRITEC
// and/or COM_WRITEF, then a one-cycle completion pulse. Every output is decoded
// from registered state, so no input has a combinational path to an output.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   i_req_valid  request present
//   o_req_ready  sequencer idle and able to accept a request
//   i_req_op     alu_op_t to perform
//   i_req_wc     write the result back to C
//   i_req_wf     write the flags back to F
//   o_alu_cmd    alu_command_t to the ALU
//   o_alu_op     alu_op_t to the ALU, meaningful while o_alu_cmd == COM_LATCHOP
//   i_alu_flags  flags_t from the ALU, bit 7 = error
//   o_busy       high in every state except IDLE
//   o_done       one-cycle completion pulse
//   o_err        error status of the last completed operation
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a request, drives COM_NOP
// LATCH   | COM_LATCHOP with the captured op, clears the exec counter
// EXEC    | COM_NOP while the ALU works, error sampled on the last cycle
// WR_C    | COM_WRITEC, result written to C
// WR_F    | COM_WRITEF, flags written to F
// DONE    | o_done pulse, o_err shows the result's error status

module alu_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [3:0] i_req_op,
    input  logic       i_req_wc,
    input  logic       i_req_wf,
    output logic [3:0] o_alu_cmd,
    output logic [3:0] o_alu_op,
    input  logic [7:0] i_alu_flags,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [3:0] COM_NOP     = 4'h0;
    localparam logic [3:0] COM_LATCHOP = 4'h1;
    localparam logic [3:0] COM_WRITEC  = 4'h2;
    localparam logic [3:0] COM_WRITEF  = 4'h3;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_CMP = 4'h4;

    // Counter value on the final EXEC cycle; unused when EXEC_CYCLES == 0.
    localparam logic [CNT_W-1:0] LAST_CNT =
        CNT_W'((EXEC_CYCLES > 0) ? EXEC_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_EXEC,
        S_WR_C,
        S_WR_F,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             wc_q, wc_d;
    logic             wf_q, wf_d;
    logic             err_q, err_d;
    logic             err_out_q, err_out_d;

    // Only the error bit of the flag bus matters here.
    logic unused_flags;
    assign unused_flags = ^i_alu_flags[6:0];

    // CMP never writes C; an error suppresses the C write but keeps F so the
    // error flag still reaches the register file.
    function automatic state_t write_decision(input logic [3:0] op,
                                              input logic       wc,
                                              input logic       wf,
                                              input logic       err);
        if (wc && (op != ALU_CMP) && !err) begin
            return S_WR_C;
        end else if (wf) begin
            return S_WR_F;
        end else begin
            return S_DONE;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= ALU_ADD;
            wc_q      <= 1'b0;
            wf_q      <= 1'b0;
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            wc_q      <= wc_d;
            wf_q      <= wf_d;
            err_q     <= err_d;
            err_out_q <= err_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        wc_d      = wc_q;
        wf_d      = wf_q;
        err_d     = err_q;
        err_out_d = err_out_q;

        case (state_q)
            S_IDLE: begin
                // Ready is always high in IDLE, so valid alone means accept.
                if (i_req_valid) begin
                    op_d      = i_req_op;
                    wc_d      = i_req_wc;
                    wf_d      = i_req_wf;
                    err_d     = 1'b0;
                    err_out_d = 1'b0;
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: begin
                cnt_d = '0;
                if (EXEC_CYCLES == 0) begin
                    err_d   = i_alu_flags[7];
                    state_d = write_decision(op_q, wc_q, wf_q, i_alu_flags[7]);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    err_d   = i_alu_flags[7];
                    state_d = write_decision(op_q, wc_q, wf_q, i_alu_flags[7]);
                end
            end
            S_WR_C: begin
                state_d = wf_q ? S_WR_F : S_DONE;
            end
            S_WR_F: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Publish the error status as DONE is entered so o_err is valid
        // alongside o_done and then holds until the next acceptance.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            err_out_d = err_d;
        end
    end

    always_comb begin
        o_alu_cmd = COM_NOP;
        case (state_q)
            S_LATCH: o_alu_cmd = COM_LATCHOP;
            S_WR_C:  o_alu_cmd = COM_WRITEC;
            S_WR_F:  o_alu_cmd = COM_WRITEF;
            default: o_alu_cmd = COM_NOP;
        endcase
    end

    assign o_alu_op    = (state_q == S_LATCH) ? op_q : ALU_ADD;
    assign o_req_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_err       = err_out_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. Two builds run side by side on the same stimulus:
// dut0 with EXEC_CYCLES = 0 and dut1 with EXEC_CYCLES = 1 (instance index
// equals its EXEC_CYCLES). A queue-based model predicts each cycle's outputs;
// directed traces add literal expectations.

module tb_alu_sequencer;

    localparam logic [3:0] C_NOP   = 4'h0;
    localparam logic [3:0] C_LATCH = 4'h1;
    localparam logic [3:0] C_WRC   = 4'h2;
    localparam logic [3:0] C_WRF   = 4'h3;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_CMP = 4'h4;
    localparam logic [3:0] OP_XOR = 4'hB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_op = 4'h0;
    logic       req_wc = 1'b0;
    logic       req_wf = 1'b0;
    logic [7:0] alu_flags = 8'h00;

    logic       rdy  [2];
    logic       busy [2];
    logic       done [2];
    logic       err  [2];
    logic [3:0] cmd  [2];
    logic [3:0] aop  [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.EXEC_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(rdy[0]),
        .i_req_op(req_op), .i_req_wc(req_wc), .i_req_wf(req_wf),
        .o_alu_cmd(cmd[0]), .o_alu_op(aop[0]), .i_alu_flags(alu_flags),
        .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
    );

    alu_sequencer #(.EXEC_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(rdy[1]),
        .i_req_op(req_op), .i_req_wc(req_wc), .i_req_wf(req_wf),
        .o_alu_cmd(cmd[1]), .o_alu_op(aop[1]), .i_alu_flags(alu_flags),
        .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
    );

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Each queue entry is what one busy cycle must look like; an empty queue
    // means idle. The entry flagged smp is the cycle whose closing edge samples
    // the error bit, which decides the write cycles appended after it.
    typedef struct packed {
        logic [3:0] cmd;
        logic [3:0] op;
        logic       done;
        logic       err;
        logic       smp;
    } exp_t;

    exp_t       mq [2][$];
    logic       m_err [2] = '{1'b0, 1'b0};
    logic [3:0] m_op  [2] = '{4'h0, 4'h0};
    logic       m_wc  [2] = '{1'b0, 1'b0};
    logic       m_wf  [2] = '{1'b0, 1'b0};

    initial forever begin
        exp_t cur;
        logic e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                m_err[i] = 1'b0;
            end else if (mq[i].size() == 0) begin
                if (req_valid) begin
                    m_op[i]  = req_op;
                    m_wc[i]  = req_wc;
                    m_wf[i]  = req_wf;
                    m_err[i] = 1'b0;
                    mq[i].push_back('{cmd:C_LATCH, op:req_op, done:1'b0, err:1'b0, smp:(i == 0)});
                    for (int k = 0; k < i; k++)
                        mq[i].push_back('{cmd:C_NOP, op:4'h0, done:1'b0, err:1'b0, smp:(k == i - 1)});
                end
            end else begin
                cur = mq[i].pop_front();
                if (cur.done) m_err[i] = cur.err;
                if (cur.smp) begin
                    e = alu_flags[7];
                    if (m_wc[i] && (m_op[i] != OP_CMP) && !e)
                        mq[i].push_back('{cmd:C_WRC, op:4'h0, done:1'b0, err:1'b0, smp:1'b0});
                    if (m_wf[i])
                        mq[i].push_back('{cmd:C_WRF, op:4'h0, done:1'b0, err:1'b0, smp:1'b0});
                    mq[i].push_back('{cmd:C_NOP, op:4'h0, done:1'b1, err:e, smp:1'b0});
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        exp_t f;
        logic idle;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            idle = (mq[i].size() == 0);
            f = idle ? '0 : mq[i][0];
            chk("model_cmd",   i, 32'(cmd[i]),  idle ? 32'(C_NOP) : 32'(f.cmd));
            chk("model_ready", i, 32'(rdy[i]),  32'(idle));
            chk("model_busy",  i, 32'(busy[i]), 32'(!idle));
            chk("model_done",  i, 32'(done[i]), idle ? 0 : 32'(f.done));
            chk("model_err",   i, 32'(err[i]),  (!idle && f.done) ? 32'(f.err) : 32'(m_err[i]));
            if (!idle && f.cmd == C_LATCH)
                chk("model_op", i, 32'(aop[i]), 32'(f.op));
        end
    end

    // ---------------- directed traces ----------------
    logic [3:0] tr_cmd  [2][16];
    logic [3:0] tr_op   [2][16];
    logic       tr_done [2][16];
    logic       tr_rdy  [2][16];
    logic       tr_err  [2][16];

    task automatic record(input int k);
        for (int i = 0; i < 2; i++) begin
            tr_cmd[i][k]  = cmd[i];
            tr_op[i][k]   = aop[i];
            tr_done[i][k] = done[i];
            tr_rdy[i][k]  = rdy[i];
            tr_err[i][k]  = err[i];
        end
    endtask

    // Called at a negedge: the next posedge is the acceptance edge (cycle 0),
    // trace entry k is sampled in cycle k.
    task automatic send(input logic [3:0] op, input logic wc, input logic wf, input int n);
        req_op = op; req_wc = wc; req_wf = wf; req_valid = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            record(k);
        end
    endtask

    function automatic int first_done(input int i, input int n);
        for (int k = 1; k <= n; k++)
            if (tr_done[i][k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int count_cmd(input int i, input logic [3:0] c, input int n);
        int cnt = 0;
        for (int k = 1; k <= n; k++)
            if (tr_cmd[i][k] === c) cnt++;
        return cnt;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_cmd",   i, 32'(cmd[i]),  32'(C_NOP));
            chk("reset_op",    i, 32'(aop[i]),  32'(OP_ADD));
            chk("reset_ready", i, 32'(rdy[i]),  1);
            chk("reset_busy",  i, 32'(busy[i]), 0);
            chk("reset_done",  i, 32'(done[i]), 0);
            chk("reset_err",   i, 32'(err[i]),  0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 1: ADD with both writes
        send(OP_ADD, 1'b1, 1'b1, 8);
        chk("t1_cmd1", 1, 32'(tr_cmd[1][1]), 1);
        chk("t1_cmd2", 1, 32'(tr_cmd[1][2]), 0);
        chk("t1_cmd3", 1, 32'(tr_cmd[1][3]), 2);
        chk("t1_cmd4", 1, 32'(tr_cmd[1][4]), 3);
        chk("t1_cmd5", 1, 32'(tr_cmd[1][5]), 0);
        chk("t1_done_cycle", 1, first_done(1, 8), 5);
        chk("t1_err", 1, 32'(tr_err[1][5]), 0);
        chk("t1_ready5", 1, 32'(tr_rdy[1][5]), 0);
        chk("t1_ready6", 1, 32'(tr_rdy[1][6]), 1);
        chk("t1_done_cycle", 0, first_done(0, 8), 4);

        // 2: CMP never writes C
        send(OP_CMP, 1'b1, 1'b1, 8);
        chk("t2_cmd1", 1, 32'(tr_cmd[1][1]), 1);
        chk("t2_cmd2", 1, 32'(tr_cmd[1][2]), 0);
        chk("t2_cmd3", 1, 32'(tr_cmd[1][3]), 3);
        chk("t2_no_writec", 1, count_cmd(1, C_WRC, 8), 0);
        chk("t2_done_cycle", 1, first_done(1, 8), 4);
        chk("t2_no_writec", 0, count_cmd(0, C_WRC, 8), 0);
        chk("t2_done_cycle", 0, first_done(0, 8), 3);

        // 3: SUB with error, C write suppressed
        alu_flags = 8'h80;
        send(OP_SUB, 1'b1, 1'b0, 8);
        alu_flags = 8'h00;
        chk("t3_no_writec", 1, count_cmd(1, C_WRC, 8), 0);
        chk("t3_no_writef", 1, count_cmd(1, C_WRF, 8), 0);
        chk("t3_done_cycle", 1, first_done(1, 8), 3);
        chk("t3_err_at_done", 1, 32'(tr_err[1][3]), 1);
        chk("t3_err_held", 1, 32'(tr_err[1][8]), 1);
        chk("t3_err_held", 0, 32'(tr_err[0][8]), 1);

        // 4: XOR, C write only; also shows o_err clearing on acceptance
        send(OP_XOR, 1'b1, 1'b0, 8);
        chk("t3_err_cleared", 1, 32'(tr_err[1][1]), 0);
        chk("t4_cmd1", 0, 32'(tr_cmd[0][1]), 1);
        chk("t4_op1",  0, 32'(tr_op[0][1]), 32'hB);
        chk("t4_cmd2", 0, 32'(tr_cmd[0][2]), 2);
        chk("t4_done_cycle", 0, first_done(0, 8), 3);
        chk("t4_done_cycle", 1, first_done(1, 8), 4);

        // 5: valid held high across two ops, op changes after acceptance
        req_op = 4'h1; req_wc = 1'b1; req_wf = 1'b0; req_valid = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            record(k);
            if (k == 1) req_op = 4'h3;
            if (k == 6) req_valid = 1'b0;
        end
        chk("t5_first_op", 1, 32'(tr_op[1][1]), 1);
        for (int k = 1; k <= 4; k++)
            chk("t5_ready_busy", 1, 32'(tr_rdy[1][k]), 0);
        chk("t5_ready_idle", 1, 32'(tr_rdy[1][5]), 1);
        chk("t5_second_latch", 1, 32'(tr_cmd[1][6]), 1);
        chk("t5_second_op", 1, 32'(tr_op[1][6]), 3);
        chk("t5_second_writec", 1, 32'(tr_cmd[1][8]), 2);
        chk("t5_first_op", 0, 32'(tr_op[0][1]), 1);
        chk("t5_second_latch", 0, 32'(tr_cmd[0][5]), 1);
        chk("t5_second_op", 0, 32'(tr_op[0][5]), 3);
        repeat (2) @(negedge clk);

        // 6: reset during dut1's EXEC cycle
        req_op = OP_ADD; req_wc = 1'b1; req_wf = 1'b1; req_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            record(k);
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
        end
        chk("t6_exec_seen", 1, 32'(tr_cmd[1][2]), 0);
        chk("t6_no_writec", 1, count_cmd(1, C_WRC, 8), 0);
        chk("t6_no_writef", 1, count_cmd(1, C_WRF, 8), 0);
        chk("t6_no_done", 1, first_done(1, 8), -1);
        chk("t6_reset_cmd", 1, 32'(tr_cmd[1][3]), 0);
        chk("t6_reset_ready", 1, 32'(tr_rdy[1][3]), 1);
        chk("t6_no_writef", 0, count_cmd(0, C_WRF, 8), 0);
        chk("t6_no_done", 0, first_done(0, 8), -1);

        send(OP_ADD, 1'b1, 1'b1, 8);
        chk("t6_after_done", 1, first_done(1, 8), 5);
        chk("t6_after_writec", 1, 32'(tr_cmd[1][3]), 2);
        chk("t6_after_done", 0, first_done(0, 8), 4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
